trigger_capture: RTL

//  Writer side of the scope's display path. Takes the ADC sample stream and waits for a rising-edge

---
 rtl/trigger_capture.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/trigger_capture.sv
// rtl/trigger_capture.sv - rising-edge triggered single-frame sample capture buffer
//
// Purpose:
//   Waits for the ADC sample stream to cross the trigger level upward. Once it
//   does, it writes DEPTH consecutive valid samples into a one-frame buffer,
//   starting with the triggering sample at address 0. The display side reads
//   the buffer by column through a synchronous read port.
//
// Configuration macro:
//   AUTO_REARM_EN - when defined, DONE re-arms by itself after HOLDOFF cycles
//                   (free-running sweeps). When undefined, DONE holds the
//                   frame until i_arm (single-shot).
//
// Ports:
//   i_clk           sole clock
//   i_rst_n         asynchronous active-low reset
//   i_arm           1-cycle pulse: start looking for a trigger (IDLE/DONE only)
//   i_sample_valid  i_sample is valid this cycle
//   i_sample        ADC sample, unsigned
//   i_trigger_level trigger threshold, unsigned
//   i_rd_addr       display read address
//   o_rd_data       buffer word at the address presented last cycle (0 if out of range)
//   o_armed         FSM is in ARMED
//   o_capturing     FSM is in CAPTURE
//   o_done          FSM is in DONE; buffer holds a complete frame

module trigger_capture #(
    parameter int DATA_W  = 10,
    parameter int DEPTH   = 640,
    parameter int ADDR_W  = 10,
    parameter int HOLDOFF = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_arm,
    input  logic              i_sample_valid,
    input  logic [DATA_W-1:0] i_sample,
    input  logic [DATA_W-1:0] i_trigger_level,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_armed,
    output logic              o_capturing,
    output logic              o_done
);

    generate
        if ((DEPTH < 2) || ((1 << ADDR_W) < DEPTH) || (HOLDOFF < 0)) begin : g_bad_params
            $error("trigger_capture: DEPTH must be >= 2, fit in ADDR_W bits, and HOLDOFF >= 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] prev_sample;
    logic              prev_valid;

`ifdef AUTO_REARM_EN
    // HOLDOFF=0 is treated as 1, so the counter loads 0 and DONE lasts one cycle.
    localparam int HOLD_W    = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
    localparam int HOLD_LOAD = (HOLDOFF > 0) ? (HOLDOFF - 1) : 0;
    logic [HOLD_W-1:0] hold_cnt;
`endif

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Rising-edge crossing: the previous valid sample was strictly below the
    // level and this one is at or above it. prev_valid blocks the first sample
    // after arming from comparing against a stale value.
    logic trigger;
    assign trigger = (state == S_ARMED) && i_sample_valid && prev_valid &&
                     (prev_sample < i_trigger_level) && (i_sample >= i_trigger_level);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    assign wr_en   = trigger || ((state == S_CAPTURE) && i_sample_valid);
    assign wr_addr = (state == S_ARMED) ? '0 : ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            prev_sample <= '0;
            prev_valid  <= 1'b0;
            o_armed     <= 1'b0;
            o_capturing <= 1'b0;
            o_done      <= 1'b0;
`ifdef AUTO_REARM_EN
            hold_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_arm) begin
                        state      <= S_ARMED;
                        prev_valid <= 1'b0;
                        o_armed    <= 1'b1;
                    end
                end

                S_ARMED: begin
                    if (i_sample_valid) begin
                        if (trigger) begin
                            // Triggering sample goes to address 0 this cycle.
                            state       <= S_CAPTURE;
                            ptr         <= ADDR_W'(1);
                            o_armed     <= 1'b0;
                            o_capturing <= 1'b1;
                        end else begin
                            prev_sample <= i_sample;
                            prev_valid  <= 1'b1;
                        end
                    end
                end

                S_CAPTURE: begin
                    if (i_sample_valid) begin
                        if (ptr == LAST_ADDR) begin
                            state       <= S_DONE;
                            o_capturing <= 1'b0;
                            o_done      <= 1'b1;
`ifdef AUTO_REARM_EN
                            hold_cnt    <= HOLD_W'(HOLD_LOAD);
`endif
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                end

                S_DONE: begin
`ifdef AUTO_REARM_EN
                    if (i_arm || (hold_cnt == '0)) begin
                        state      <= S_ARMED;
                        prev_valid <= 1'b0;
                        o_done     <= 1'b0;
                        o_armed    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
`else
                    if (i_arm) begin
                        state      <= S_ARMED;
                        prev_valid <= 1'b0;
                        o_done     <= 1'b0;
                        o_armed    <= 1'b1;
                    end
`endif
                end

                default: begin
                    state       <= S_IDLE;
                    o_armed     <= 1'b0;
                    o_capturing <= 1'b0;
                    o_done      <= 1'b0;
                end
            endcase
        end
    end

    // Frame buffer. Not reset: contents are only meaningful once o_done is set.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= i_sample;
        end
    end

    // Read-first: a same-cycle write to the read address is seen on the next read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= '0;
        end else if (int'(i_rd_addr) < DEPTH) begin
            o_rd_data <= mem[i_rd_addr];
        end else begin
            o_rd_data <= '0;
        end
    end

endmodule
